// File: rtl/b11_scrambler_gen.sv
// ---------------------------------------------------------------------------
// b11_scrambler_gen
//
// Parametrised b11 string-scrambler datapath. A W-bit symbol is captured on
// the first clock edge that sees stbi low while the block is waiting. The
// symbol is classified, folded with a persistent transaction counter through
// modular add/subtract reduction and a 4-way offset table, and the magnitude
// of the signed result is presented on x_out with a one-cycle out_valid pulse.
//
// Parameters: W is the symbol width (at least 4). The modulus parameter also
// serves as the acceptance bound, so symbols above it are rejected. LIMIT is
// the counter value at which a trivial symbol wraps cont back to 0. K0..K3 are
// the offsets applied in OFS, selected by r_in[3:2]
// (00: -K0, 01: -K1, 10: +K2, 11: +K3).
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-low reset
//   x_in       input symbol
//   stbi       active-low strobe, only looked at while waiting
//   x_out      result magnitude, holds between results
//   out_valid  one-cycle pulse coincident with an x_out update
//   reject     one-cycle pulse when the captured symbol exceeds the modulus
//   busy       high in every state except IDLE and WAIT
// ---------------------------------------------------------------------------
module b11_scrambler_gen #(
  parameter int W     = 6,
  parameter int MOD   = 26,
  parameter int LIMIT = 25,
  parameter int K0    = 21,
  parameter int K1    = 42,
  parameter int K2    = 7,
  parameter int K3    = 28
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         stbi,
  output logic [W-1:0] x_out,
  output logic         out_valid,
  output logic         reject,
  output logic         busy
);

  // Accumulator width: three guard bits above the symbol width so that the
  // doubled counter plus a symbol, and the offset subtraction, never wrap.
  localparam int AW = W + 3;

  localparam logic [W-1:0]         MOD_W   = W'(MOD);
  localparam logic [W-1:0]         LIMIT_W = W'(LIMIT);
  localparam logic signed [AW-1:0] MOD_A   = AW'(MOD);
  localparam logic signed [AW-1:0] TOP_A   = AW'((1 << W) - 1);
  localparam logic signed [AW-1:0] K0_A    = AW'(K0);
  localparam logic signed [AW-1:0] K1_A    = AW'(K1);
  localparam logic signed [AW-1:0] K2_A    = AW'(K2);
  localparam logic signed [AW-1:0] K3_A    = AW'(K3);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT,
    S_CLASS,
    S_SEED,
    S_MIX,
    S_UP,
    S_DN,
    S_OFS,
    S_EMIT
  } state_t;

  state_t state;
  state_t state_next;

  logic [W-1:0]         r_in;
  logic [W-1:0]         r_in_next;
  logic [W-1:0]         cont;
  logic [W-1:0]         cont_next;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic [W-1:0]         x_out_next;
  logic                 out_valid_next;
  logic                 reject_next;

  logic                 trivial;
  logic signed [AW-1:0] r_in_ext;
  logic signed [AW-1:0] seed_val;
  logic signed [AW-1:0] mag;

  // Shared operand preparation. Symbols and the counter are zero-extended
  // into the accumulator width; the seed is either cont or 2*cont depending
  // on the symbol's LSB. mag is |acc|, truncated to W bits on output.
  always_comb begin
    trivial  = (r_in == '0) || (r_in == '1);
    r_in_ext = {{(AW - W){1'b0}}, r_in};
    if (r_in[0]) begin
      seed_val = {{(AW - W - 1){1'b0}}, cont, 1'b0};
    end else begin
      seed_val = {{(AW - W){1'b0}}, cont};
    end
    if (acc[AW-1]) begin
      mag = -acc;
    end else begin
      mag = acc;
    end
  end

  // Next-state and next-register logic. Status pulses default low so they
  // only ever last one cycle.
  always_comb begin
    state_next     = state;
    r_in_next      = r_in;
    cont_next      = cont;
    acc_next       = acc;
    x_out_next     = x_out;
    out_valid_next = 1'b0;
    reject_next    = 1'b0;

    case (state)
      S_IDLE: begin
        x_out_next = '0;
        state_next = S_WAIT;
      end

      // r_in tracks x_in continuously so the captured symbol is exactly the
      // one present on the strobe edge.
      S_WAIT: begin
        r_in_next = x_in;
        if (!stbi) begin
          state_next = S_CLASS;
        end
      end

      // Trivial symbols bypass the mixer and only advance the counter.
      // Oversize symbols are dropped without touching acc, cont or x_out.
      S_CLASS: begin
        if (trivial) begin
          if (cont < LIMIT_W) begin
            cont_next = cont + 1'b1;
          end else begin
            cont_next = '0;
          end
          acc_next   = r_in_ext;
          state_next = S_EMIT;
        end else if (r_in <= MOD_W) begin
          state_next = S_SEED;
        end else begin
          reject_next = 1'b1;
          state_next  = S_WAIT;
        end
      end

      S_SEED: begin
        acc_next   = seed_val;
        state_next = S_MIX;
      end

      S_MIX: begin
        if (r_in[1]) begin
          acc_next   = r_in_ext + acc;
          state_next = S_UP;
        end else begin
          acc_next   = r_in_ext - acc;
          state_next = S_DN;
        end
      end

      // Iterative reduction, one modulus step per cycle.
      S_UP: begin
        if (acc > MOD_A) begin
          acc_next = acc - MOD_A;
        end else begin
          state_next = S_OFS;
        end
      end

      S_DN: begin
        if (acc > TOP_A) begin
          acc_next = acc + MOD_A;
        end else begin
          state_next = S_OFS;
        end
      end

      S_OFS: begin
        case (r_in[3:2])
          2'b00:   acc_next = acc - K0_A;
          2'b01:   acc_next = acc - K1_A;
          2'b10:   acc_next = acc + K2_A;
          default: acc_next = acc + K3_A;
        endcase
        state_next = S_EMIT;
      end

      S_EMIT: begin
        x_out_next     = W'(mag);
        out_valid_next = 1'b1;
        state_next     = S_WAIT;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset is synchronous and overrides any
  // state, including an in-progress reduction loop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      r_in      <= '0;
      cont      <= '0;
      acc       <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
      reject    <= 1'b0;
    end else begin
      state     <= state_next;
      r_in      <= r_in_next;
      cont      <= cont_next;
      acc       <= acc_next;
      x_out     <= x_out_next;
      out_valid <= out_valid_next;
      reject    <= reject_next;
    end
  end

  // Inputs are only listened to in IDLE/WAIT; everything else is busy.
  always_comb begin
    busy = (state != S_IDLE) && (state != S_WAIT);
  end

endmodule

// File: tb/tb_b11_scrambler_gen.sv
// ---------------------------------------------------------------------------
// tb_b11_scrambler_gen
//
// Self-checking bench for b11_scrambler_gen with default parameters. Expected
// results come from an integer model of the scrambling rules; outputs are
// sampled on the falling edge, inputs driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_b11_scrambler_gen;

  localparam int W     = 6;
  localparam int MOD   = 26;
  localparam int LIMIT = 25;
  localparam int K0    = 21;
  localparam int K1    = 42;
  localparam int K2    = 7;
  localparam int K3    = 28;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] x_in  = '0;
  logic         stbi  = 1'b1;
  logic [W-1:0] x_out;
  logic         out_valid;
  logic         reject;
  logic         busy;

  int testCount = 0;
  int failCount = 0;
  int modelCont = 0;
  int modelXout = 0;

  b11_scrambler_gen #(
    .W(W), .MOD(MOD), .LIMIT(LIMIT),
    .K0(K0), .K1(K1), .K2(K2), .K3(K3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .x_in(x_in),
    .stbi(stbi),
    .x_out(x_out),
    .out_valid(out_valid),
    .reject(reject),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Integer model of one transaction: result value, cycles from the sampling
  // edge to the result edge, and whether the symbol is rejected.
  task automatic modelTransaction(input logic [W-1:0] sym, output int expX,
                                  output int expLat, output bit expRej);
    int a;
    int n;
    int symV;
    symV   = int'(sym);
    expRej = 1'b0;
    if (symV == 0 || symV == (1 << W) - 1) begin
      modelCont = (modelCont < LIMIT) ? modelCont + 1 : 0;
      expX      = symV;
      expLat    = 2;
      modelXout = expX;
    end else if (symV > MOD) begin
      expRej = 1'b1;
      expX   = modelXout;
      expLat = 1;
    end else begin
      a = sym[0] ? 2 * modelCont : modelCont;
      n = 0;
      if (sym[1]) begin
        a = symV + a;
        if (a > MOD) n = (a - MOD + MOD - 1) / MOD;
        a = a - n * MOD;
      end else begin
        // symbol minus a non-negative seed never exceeds MOD < 2^W,
        // so the down-reduction never iterates
        a = symV - a;
      end
      case (sym[3:2])
        2'b00:   a = a - K0;
        2'b01:   a = a - K1;
        2'b10:   a = a + K2;
        default: a = a + K3;
      endcase
      if (a < 0) a = -a;
      expX      = a % (1 << W);
      expLat    = 6 + n;
      modelXout = expX;
    end
  endtask

  // One full transaction: strobe the symbol, then check quiet/busy cycles
  // and the result cycle. Inputs are scrambled while busy to show they are
  // ignored. Called and returns on a falling edge with the FSM in WAIT.
  task automatic applyStimulus(input logic [W-1:0] sym, input string tag);
    int expX;
    int expLat;
    bit expRej;
    modelTransaction(sym, expX, expLat, expRej);
    x_in = sym;
    stbi = 1'b0;
    for (int k = 0; k <= expLat; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k < expLat) begin
        checkOutput({tag, "/quiet"}, {30'd0, out_valid, reject}, 32'd0);
        checkOutput({tag, "/busy"}, {31'd0, busy}, 32'd1);
        x_in = W'($urandom);
        stbi = 1'($urandom_range(0, 1));
      end else begin
        checkOutput({tag, "/out_valid"}, {31'd0, out_valid}, {31'd0, !expRej});
        checkOutput({tag, "/reject"}, {31'd0, reject}, {31'd0, expRej});
        checkOutput({tag, "/x_out"}, {26'd0, x_out}, expX);
        checkOutput({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
        stbi = 1'b1;
      end
    end
  endtask

  // Start a symbol that takes the UP path and pull reset low for two edges
  // while the FSM is in UP.
  task automatic resetMidUp();
    x_in = 6'd3;
    stbi = 1'b0;
    @(posedge clock);
    @(negedge clock);
    stbi = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("mid_up/busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("mid_up/x_out", {26'd0, x_out}, 32'd0);
    checkOutput("mid_up/out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_up/reject", {31'd0, reject}, 32'd0);
    checkOutput("mid_up/busy_rst", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("mid_up/wait_busy", {31'd0, busy}, 32'd0);
    modelCont = 0;
    modelXout = 0;
  endtask

  initial begin
    logic [W-1:0] sym;
    int r;

    reset = 1'b0;
    stbi  = 1'b1;
    x_in  = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset/x_out", {26'd0, x_out}, 32'd0);
    checkOutput("reset/out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset/reject", {31'd0, reject}, 32'd0);
    checkOutput("reset/busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("reset/wait_busy", {31'd0, busy}, 32'd0);

    applyStimulus(6'd0, "triv0");
    applyStimulus(6'd63, "triv63");
    applyStimulus(6'd3, "up3");
    applyStimulus(6'd30, "rej30");

    applyStimulus(6'd0, "pre_rst0");
    resetMidUp();
    applyStimulus(6'd5, "dn5");

    for (int i = 0; i < 26; i++) begin
      applyStimulus(6'd0, "wrap0");
    end
    applyStimulus(6'd3, "wrap3");

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      sym = ($urandom_range(0, 1) == 1) ? 6'd63 : 6'd0;
      else if (r < 6) sym = W'($urandom_range(1, MOD));
      else            sym = W'($urandom_range(0, 63));
      applyStimulus(sym, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
